// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: command codes, FSM states and strobe bundle for the accumulator sequencer
package acc_seq_pkg;
    localparam int W_DEF  = 4;
    localparam int CW_DEF = 8;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_LOAD = 3'd1,
        CMD_ALU  = 3'd2,
        CMD_INC  = 3'd3,
        CMD_DEC  = 3'd4,
        CMD_SHR  = 3'd5,
        CMD_SHL  = 3'd6,
        CMD_CLR  = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic cl;
        logic ld;
        logic inc;
        logic dec;
        logic sr;
        logic sl;
        logic ir;
        logic il;
    } strb_t;
endpackage

// File: rtl/acc_seq_decode.sv
// acc_seq_decode: maps a command code and shift-in bit to the register strobe set
module acc_seq_decode
    import acc_seq_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic       i_bit,
    output strb_t      o_strb
);
    // one-hot operation strobe; shift-in bits ride only with their shift
    always_comb begin
        o_strb     = '0;
        o_strb.cl  = (i_op == CMD_CLR);
        o_strb.ld  = (i_op == CMD_LOAD) || (i_op == CMD_ALU);
        o_strb.inc = (i_op == CMD_INC);
        o_strb.dec = (i_op == CMD_DEC);
        o_strb.sr  = (i_op == CMD_SHR);
        o_strb.sl  = (i_op == CMD_SHL);
        o_strb.ir  = (i_op == CMD_SHR) && i_bit;
        o_strb.il  = (i_op == CMD_SHL) && i_bit;
    end
endmodule

// File: rtl/acc_sequencer.sv
// acc_sequencer: turns accumulator commands into alu/register control with a response channel
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [2:0]    cmd_oc,
    input  logic [W-1:0]  cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_data,
    output logic [CW-1:0] cmd_count,
    output logic [2:0]    alu_oc,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [W-1:0]  alu_f,
    output logic          reg_cl,
    output logic          reg_ld,
    output logic          reg_inc,
    output logic          reg_dec,
    output logic          reg_sr,
    output logic          reg_ir,
    output logic          reg_sl,
    output logic          reg_il,
    output logic [W-1:0]  reg_in,
    input  logic [W-1:0]  reg_q
);
    state_e        r_state, w_next;
    logic [2:0]    r_op, r_oc;
    logic [W-1:0]  r_data;
    logic [CW-1:0] r_count;
    strb_t         r_strb, w_strb;
    logic          w_cmd_hs, w_rsp_hs;

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_rsp_hs  = rsp_valid && rsp_ready;

    // decoded from the command being latched so strobes rise on the acceptance edge
    acc_seq_decode u_dec (
        .i_op   (cmd_op),
        .i_bit  (cmd_data[0]),
        .o_strb (w_strb)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // IDLE -> EXEC on accept, EXEC -> RESP always, RESP -> IDLE on response accept
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // latch the command and hold its strobes for exactly the EXEC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_oc   <= '0;
            r_data <= '0;
            r_strb <= '0;
        end else begin
            if (w_cmd_hs) begin
                r_op   <= cmd_op;
                r_oc   <= cmd_oc;
                r_data <= cmd_data;
            end
            r_strb <= w_cmd_hs ? w_strb : '0;
        end
    end

    // completed-command counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_count <= '0;
        else if (w_rsp_hs) r_count <= r_count + 1'b1;
    end

    assign cmd_count = r_count;
    assign alu_oc    = r_oc;
    assign alu_b     = r_data;
    assign alu_a     = reg_q;
    assign rsp_data  = reg_q;
    assign reg_in    = (r_op == CMD_LOAD) ? r_data : (r_op == CMD_ALU) ? alu_f : '0;
    assign reg_cl    = r_strb.cl;
    assign reg_ld    = r_strb.ld;
    assign reg_inc   = r_strb.inc;
    assign reg_dec   = r_strb.dec;
    assign reg_sr    = r_strb.sr;
    assign reg_ir    = r_strb.ir;
    assign reg_sl    = r_strb.sl;
    assign reg_il    = r_strb.il;
endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: table-driven check of acc_sequencer against behavioural alu/register models
module tb_acc_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [2:0] cmd_op = '0, cmd_oc = '0;
    logic [3:0] cmd_data = '0;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic [7:0] cmd_count;
    logic [2:0] alu_oc;
    logic [3:0] alu_a, alu_b, alu_f, reg_in;
    logic [3:0] q = 4'd0;
    logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
    logic [7:0] strb;

    int n_chk = 0;
    int n_pass = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    acc_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_oc(cmd_oc), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .cmd_count(cmd_count),
        .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
        .reg_sr(reg_sr), .reg_ir(reg_ir), .reg_sl(reg_sl), .reg_il(reg_il),
        .reg_in(reg_in), .reg_q(q)
    );

    function automatic logic [3:0] alu_fn(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
        case (oc)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a + b;
            3'd4:    return a - b;
            3'd5:    return ~a;
            3'd6:    return b;
            default: return a;
        endcase
    endfunction

    assign alu_f = alu_fn(alu_oc, alu_a, alu_b);
    assign strb  = {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il};

    always @(posedge clk) begin
        if      (reg_cl)  q <= 4'd0;
        else if (reg_ld)  q <= reg_in;
        else if (reg_inc) q <= q + 4'd1;
        else if (reg_dec) q <= q - 4'd1;
        else if (reg_sr)  q <= {reg_ir, q[3:1]};
        else if (reg_sl)  q <= {q[2:0], reg_il};
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [2:0] oc;
        logic [3:0] data;
        logic [7:0] strb;
        logic [3:0] rsp;
        int         hold;
    } rec_t;

    task automatic run_cmd(input rec_t r);
        logic [3:0] a0;
        logic [3:0] exp_in;
        @(negedge clk);
        a0 = q;
        cmd_valid = 1'b1; cmd_op = r.op; cmd_oc = r.oc; cmd_data = r.data; rsp_ready = 1'b0;
        @(negedge clk);
        exp_in = (r.op == 3'd2) ? alu_fn(r.oc, a0, r.data) : (r.op == 3'd1) ? r.data : 4'd0;
        chk("exec_strb", strb, r.strb);
        chk("exec_cmd_ready", cmd_ready, 0);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_alu_a", alu_a, a0);
        if (r.op == 3'd2) begin
            chk("exec_alu_oc", alu_oc, r.oc);
            chk("exec_alu_b", alu_b, r.data);
        end
        chk("exec_reg_in", reg_in, exp_in);
        cmd_valid = (r.hold > 0); cmd_op = 3'd7; cmd_data = 4'hF;
        @(negedge clk);
        chk("resp_valid", rsp_valid, 1);
        chk("resp_data", rsp_data, r.rsp);
        chk("resp_strb", strb, 0);
        for (int i = 0; i < r.hold; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_strb", strb, 0);
            chk("bp_rsp_data", rsp_data, r.rsp);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        exp_cnt = (exp_cnt + 1) % 256;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_cmd_ready", cmd_ready, 1);
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_count", cmd_count, exp_cnt);
    endtask

    rec_t tbl[13];

    initial begin
        tbl[0]  = '{3'd1, 3'd0, 4'b1010, 8'b0100_0000, 4'b1010, 0};
        tbl[1]  = '{3'd1, 3'd0, 4'd2,    8'b0100_0000, 4'd2,    0};
        tbl[2]  = '{3'd2, 3'd3, 4'd5,    8'b0100_0000, 4'd7,    0};
        tbl[3]  = '{3'd3, 3'd0, 4'd0,    8'b0010_0000, 4'd8,    0};
        tbl[4]  = '{3'd4, 3'd0, 4'd0,    8'b0001_0000, 4'd7,    0};
        tbl[5]  = '{3'd5, 3'd0, 4'd1,    8'b0000_1010, 4'b1011, 0};
        tbl[6]  = '{3'd7, 3'd0, 4'd0,    8'b1000_0000, 4'd0,    0};
        tbl[7]  = '{3'd1, 3'd0, 4'b0110, 8'b0100_0000, 4'b0110, 0};
        tbl[8]  = '{3'd6, 3'd0, 4'd1,    8'b0000_0101, 4'b1101, 5};
        tbl[9]  = '{3'd0, 3'd0, 4'd9,    8'b0000_0000, 4'b1101, 0};
        tbl[10] = '{3'd2, 3'd4, 4'd3,    8'b0100_0000, 4'b1010, 0};
        tbl[11] = '{3'd1, 3'd0, 4'hF,    8'b0100_0000, 4'hF,    0};
        tbl[12] = '{3'd3, 3'd0, 4'd0,    8'b0010_0000, 4'd0,    0};

        #7 rst_n = 1'b1;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_strb", strb, 0);
        chk("rst_count", cmd_count, 0);
        chk("rst_alu_oc", alu_oc, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_reg_in", reg_in, 0);

        foreach (tbl[i]) run_cmd(tbl[i]);

        begin : reset_mid_exec
            logic [3:0] q0;
            @(negedge clk);
            q0 = q;
            cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = 4'd0;
            @(posedge clk);
            #2;
            cmd_valid = 1'b0;
            chk("inc_strobe_up", reg_inc, 1);
            rst_n = 1'b0;
            #1;
            chk("async_inc_drop", reg_inc, 0);
            chk("async_cmd_ready", cmd_ready, 1);
            chk("async_rsp_valid", rsp_valid, 0);
            chk("async_count", cmd_count, 0);
            @(negedge clk);
            rst_n = 1'b1;
            exp_cnt = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("post_rst_idle", cmd_ready, 1);
                chk("post_rst_no_rsp", rsp_valid, 0);
            end
            chk("post_rst_q_kept", rsp_data, q0);
        end

        begin : nop_burst
            int n = 0;
            int cyc = 0;
            bit hs = 1'b0;
            bit strobe_seen = 1'b0;
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 4'hF; rsp_ready = 1'b1;
            while (n < 256 && cyc < 2000) begin
                @(negedge clk);
                cyc++;
                if (strb != 0) strobe_seen = 1'b1;
                if (hs) begin
                    n++;
                    if (n == 255) chk("nop_count_255", cmd_count, 255);
                    if (n == 256) chk("nop_count_wrap", cmd_count, 0);
                end
                hs = rsp_valid && rsp_ready;
            end
            cmd_valid = 1'b0; rsp_ready = 1'b0;
            chk("nop_burst_done", n, 256);
            chk("nop_no_strobe", strobe_seen, 0);
            chk("nop_throughput", cyc, 768);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
